sseg_scan: RTL and testbench
============================

// Module: sseg_scan
// PURPOSE
//   Time-multiplexed scan controller for the 6-digit seven-segment display.
//   Holds a 6-entry digit buffer, steps digit_pos 0..5 and presents each
//   digit code to the combinational sseg decoder. Inserts a blanking gap
//   between digits to suppress ghosting. Buffer updates are tear-free:
//   they commit only at a frame boundary.
// PARAMETERS
//   DWELL_CYCLES  50000  clocks each digit is driven (>=2)
//   BLANK_CYCLES  500    clocks of blanking after each digit (>=1)
// PORTS
//   clk          in   1   system clock
//   rst_n        in   1   reset, asynchronous, active-low
//   enable       in   1   1 = scan, 0 = display off
//   load         in   1   1-cycle strobe: capture load_digits into shadow
//   load_digits  in   30  digit k = [5k+4:5k]; bit4 = DP on, [3:0] = value
//   digit        out  5   code to decoder; 5'h0F = blank (all segments off)
//   digit_pos    out  3   position to decoder; 0..5 active, 7 = none selected
//   frame_start  out  1   1-cycle pulse on first SHOW cycle of position 0
//   load_ack     out  1   1-cycle pulse when shadow commits to active buffer
// BEHAVIOUR
//   - All outputs registered. Reset: digit=5'h0F, digit_pos=3'd7,
//     frame_start=0, load_ack=0, active and shadow entries all 5'h0F,
//     pending=0, counters=0, state=OFF.
//   - States: OFF, SHOW, BLANK.
//     OFF:   digit_pos=7, digit=5'h0F. enable=1 -> SHOW with pos=0 next cycle.
//     SHOW:  digit_pos=pos, digit=active[pos], held for exactly DWELL_CYCLES
//            clocks, then -> BLANK.
//     BLANK: digit_pos=7, digit=5'h0F for exactly BLANK_CYCLES clocks. Then
//            if pos<5: pos+1, -> SHOW. If pos==5: frame boundary, pos=0, -> SHOW.
//   - Per-digit period = DWELL_CYCLES+BLANK_CYCLES; frame = 6x that.
//   - frame_start high only on the first SHOW cycle of pos 0.
//   - load: shadow <= load_digits, pending <= 1. A second load before commit
//     overwrites the shadow; only one load_ack is issued.
//   - Commit (active <= shadow, pending <= 0, load_ack pulse) happens on the
//     last BLANK cycle of pos 5 if pending, or on any cycle in OFF if pending.
//     The new data is visible from the following SHOW of pos 0.
//   - load on the same cycle as a commit: load_digits go directly to active,
//     pending ends 0, and exactly one load_ack is issued.
//   - enable falls in SHOW or BLANK: next cycle is OFF (digit_pos=7,
//     digit=5'h0F). pos and counters clear. A pending load commits in OFF.
//   - Value nibbles 10..15 are passed through unchanged; the decoder blanks
//     them.
//   - rst_n assertion at any time forces reset values immediately. After
//     release, the first scan begins one cycle after enable is seen high.
// TESTING  (bench: DWELL_CYCLES=4, BLANK_CYCLES=1)
//   1 reset, enable=1 -> digit_pos 0,0,0,0,7,1,1,1,1,7,...5,7,0; period 30;
//     frame_start once per 30 clk; digit=5'h0F throughout (buffer blank).
//   2 load digits {5'h15,0x03,0x02,0x01,0x00,0x09} (pos5..0) mid-frame ->
//     load_ack at last BLANK of pos5; next pos0 shows 5'h09; pos5 shows 5'h15.
//   3 two loads (A then B) in one frame -> single load_ack; B displayed, A never.
//   4 load on the exact commit cycle with value C -> one load_ack; C shown at pos0.
//   5 enable dropped during SHOW pos3 -> next cycle digit_pos=7, digit=5'h0F;
//     re-enable -> restart at pos0 with frame_start.
//   6 rst_n pulsed low mid-SHOW -> outputs immediately at reset values;
//     buffer reads back blank (5'h0F at all positions).

Source files
------------

// File: rtl/sseg_scan.sv
// Time-multiplexed scan controller for a 6-digit seven-segment display.
// Latency: registered outputs, so a state change is visible one clock after the deciding edge.
// Flow: no backpressure. A load is held in a shadow buffer and copied to the display buffer only at a frame boundary.
//
// Ports:
//   clk, rst_n      clock; asynchronous, active-low reset
//   enable          1 = scan, 0 = display off
//   load            1-cycle strobe; load_digits is captured into the shadow buffer
//   load_digits     digit k = [5k+4:5k]; bit4 = DP, [3:0] = value
//   digit           code to the decoder; 5'h0F = blank
//   digit_pos       position to the decoder; 0..5 active, 7 = none selected
//   frame_start     pulse on the first SHOW cycle of position 0
//   load_ack        pulse when the shadow buffer commits to the active buffer
module sseg_scan #(
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        load,
    input  logic [29:0] load_digits,
    output logic [4:0]  digit,
    output logic [2:0]  digit_pos,
    output logic        frame_start,
    output logic        load_ack
);

    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW      = $clog2(CNT_MAX);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [4:0]    BLANK_CODE = 5'h0F;
    localparam logic [2:0]    POS_NONE   = 3'd7;
    localparam logic [2:0]    POS_LAST   = 3'd5;
    localparam logic [29:0]   ALL_BLANK  = {6{BLANK_CODE}};

    typedef enum logic [1:0] {ST_OFF, ST_SHOW, ST_BLANK} state_t;

    state_t      state, state_nxt;
    logic [2:0]  pos, pos_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [29:0] active, active_nxt;
    logic [29:0] shadow, shadow_nxt;
    logic        pending, pending_nxt;
    logic        frame_end, commit;
    logic [4:0]  digit_nxt;
    logic [2:0]  digit_pos_nxt;
    logic        frame_start_nxt;

    function automatic logic [4:0] pick(input logic [29:0] buf_v, input logic [2:0] p);
        logic [4:0] r;
        case (p)
            3'd0:    r = buf_v[4:0];
            3'd1:    r = buf_v[9:5];
            3'd2:    r = buf_v[14:10];
            3'd3:    r = buf_v[19:15];
            3'd4:    r = buf_v[24:20];
            3'd5:    r = buf_v[29:25];
            default: r = BLANK_CODE;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_OFF;
            pos         <= 3'd0;
            cnt         <= '0;
            active      <= ALL_BLANK;
            shadow      <= ALL_BLANK;
            pending     <= 1'b0;
            digit       <= BLANK_CODE;
            digit_pos   <= POS_NONE;
            frame_start <= 1'b0;
            load_ack    <= 1'b0;
        end else begin
            state       <= state_nxt;
            pos         <= pos_nxt;
            cnt         <= cnt_nxt;
            active      <= active_nxt;
            shadow      <= shadow_nxt;
            pending     <= pending_nxt;
            digit       <= digit_nxt;
            digit_pos   <= digit_pos_nxt;
            frame_start <= frame_start_nxt;
            load_ack    <= commit;
        end
    end

    always_comb begin
        state_nxt   = state;
        pos_nxt     = pos;
        cnt_nxt     = cnt;
        active_nxt  = active;
        shadow_nxt  = shadow;
        pending_nxt = pending;

        case (state)
            ST_OFF: begin
                if (enable) begin
                    state_nxt = ST_SHOW;
                    pos_nxt   = 3'd0;
                    cnt_nxt   = '0;
                end
            end
            ST_SHOW: begin
                if (!enable) begin
                    state_nxt = ST_OFF;
                    pos_nxt   = 3'd0;
                    cnt_nxt   = '0;
                end else if (cnt == DWELL_LAST) begin
                    state_nxt = ST_BLANK;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_BLANK: begin
                if (!enable) begin
                    state_nxt = ST_OFF;
                    pos_nxt   = 3'd0;
                    cnt_nxt   = '0;
                end else if (cnt == BLANK_LAST) begin
                    state_nxt = ST_SHOW;
                    cnt_nxt   = '0;
                    pos_nxt   = (pos == POS_LAST) ? 3'd0 : pos + 3'd1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_OFF;
                pos_nxt   = 3'd0;
                cnt_nxt   = '0;
            end
        endcase

        // The last blanking cycle of position 5 is the only in-scan point
        // where swapping the buffer cannot tear a frame. While off there
        // is nothing on the display, so any cycle is safe.
        frame_end = (state == ST_BLANK) && (pos == POS_LAST) && (cnt == BLANK_LAST);
        commit    = pending && ((state == ST_OFF) || frame_end);

        if (commit) begin
            // A load arriving on the commit cycle is newer than the shadow,
            // so it goes straight to the display buffer.
            active_nxt  = load ? load_digits : shadow;
            pending_nxt = 1'b0;
        end else if (load) begin
            shadow_nxt  = load_digits;
            pending_nxt = 1'b1;
        end

        // Outputs are derived from the next state so that they can be
        // registered without adding a cycle of lag relative to the FSM.
        if (state_nxt == ST_SHOW) begin
            digit_nxt     = pick(active_nxt, pos_nxt);
            digit_pos_nxt = pos_nxt;
        end else begin
            digit_nxt     = BLANK_CODE;
            digit_pos_nxt = POS_NONE;
        end
        frame_start_nxt = (state_nxt == ST_SHOW) && (pos_nxt == 3'd0) && (state != ST_SHOW);
    end

endmodule

// File: tb/tb_sseg_scan.sv
module tb_sseg_scan;

    localparam int DW  = 4;
    localparam int BL  = 1;
    localparam int PER = DW + BL;
    localparam int FR  = 6 * PER;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        load;
    logic [29:0] load_digits;
    logic [4:0]  digit;
    logic [2:0]  digit_pos;
    logic        frame_start;
    logic        load_ack;

    sseg_scan #(.DWELL_CYCLES(DW), .BLANK_CYCLES(BL)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .load        (load),
        .load_digits (load_digits),
        .digit       (digit),
        .digit_pos   (digit_pos),
        .frame_start (frame_start),
        .load_ack    (load_ack)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] digit;
        logic [2:0] pos;
        logic       fs;
        logic       ack;
    } exp_t;

    exp_t sbq[$];

    int n_assert = 0;
    int n_fail   = 0;
    int ack_seen = 0;
    int fs_seen  = 0;

    // Behavioural model: scan position expressed as a phase 0..FR-1 within the frame.
    bit         m_on;
    int         m_t;
    logic [4:0] m_act [6];
    logic [4:0] m_sh  [6];
    bit         m_pend;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_on   = 1'b0;
        m_t    = 0;
        m_pend = 1'b0;
        for (int k = 0; k < 6; k++) begin
            m_act[k] = 5'h0F;
            m_sh[k]  = 5'h0F;
        end
        sbq.delete();
    endtask

    task automatic model_step(input logic e, input logic l, input logic [29:0] d);
        bit   commit;
        exp_t x;
        commit = m_pend && (!m_on || (m_t == FR - 1));
        if (commit) begin
            for (int k = 0; k < 6; k++) m_act[k] = l ? d[5*k +: 5] : m_sh[k];
            m_pend = 1'b0;
        end else if (l) begin
            for (int k = 0; k < 6; k++) m_sh[k] = d[5*k +: 5];
            m_pend = 1'b1;
        end
        if (!m_on) begin
            m_on = e;
            m_t  = 0;
        end else if (!e) begin
            m_on = 1'b0;
            m_t  = 0;
        end else begin
            m_t = (m_t + 1) % FR;
        end
        x.ack = commit;
        if (m_on && ((m_t % PER) < DW)) begin
            x.pos   = 3'(m_t / PER);
            x.digit = m_act[m_t / PER];
        end else begin
            x.pos   = 3'd7;
            x.digit = 5'h0F;
        end
        x.fs = m_on && (m_t == 0);
        sbq.push_back(x);
    endtask

    task automatic check_out();
        exp_t x;
        n_assert++;
        assert (sbq.size() > 0) else begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=%0d expected=>0", sbq.size());
        end
        if (sbq.size() > 0) begin
            x = sbq.pop_front();
            chk("digit",       8'(digit),       8'(x.digit));
            chk("digit_pos",   8'(digit_pos),   8'(x.pos));
            chk("frame_start", 8'(frame_start), 8'(x.fs));
            chk("load_ack",    8'(load_ack),    8'(x.ack));
        end
        ack_seen += int'(load_ack);
        fs_seen  += int'(frame_start);
    endtask

    task automatic step(input logic e, input logic l, input logic [29:0] d);
        enable      = e;
        load        = l;
        load_digits = d;
        model_step(e, l, d);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 30'd0);
    endtask

    // Advance (enabled) until the model sits at phase t; bounded by two frames.
    task automatic run_until(input int t);
        for (int i = 0; i < 2 * FR && !(m_on && m_t == t); i++) step(1'b1, 1'b0, 30'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_digit"},       8'(digit),       8'h0F);
        chk({tag, "_digit_pos"},   8'(digit_pos),   8'h07);
        chk({tag, "_frame_start"}, 8'(frame_start), 8'h00);
        chk({tag, "_load_ack"},    8'(load_ack),    8'h00);
    endtask

    initial begin
        rst_n       = 1'b0;
        enable      = 1'b0;
        load        = 1'b0;
        load_digits = 30'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // 1: blank-buffer scan, two frame_start pulses in two frames
        fs_seen = 0;
        run(2 * FR);
        chk("t1_frame_starts", 8'(fs_seen), 8'd2);

        // 2: load mid-frame, commit at the frame boundary
        run_until(10);
        ack_seen = 0;
        step(1'b1, 1'b1, {5'h15, 5'h03, 5'h02, 5'h01, 5'h00, 5'h09});
        run(2 * FR);
        chk("t2_ack_count", 8'(ack_seen), 8'd1);

        // 3: two loads in one frame, only the second is ever shown
        run_until(3);
        ack_seen = 0;
        step(1'b1, 1'b1, {5'h0A, 5'h0A, 5'h0A, 5'h0A, 5'h0A, 5'h0A});
        run(5);
        step(1'b1, 1'b1, {5'h17, 5'h06, 5'h05, 5'h04, 5'h13, 5'h08});
        run(2 * FR);
        chk("t3_ack_count", 8'(ack_seen), 8'd1);

        // 4: load arriving on the exact commit cycle overrides the shadow
        run_until(8);
        step(1'b1, 1'b1, {5'h01, 5'h01, 5'h01, 5'h01, 5'h01, 5'h01});
        run_until(FR - 1);
        ack_seen = 0;
        step(1'b1, 1'b1, {5'h1C, 5'h0B, 5'h0E, 5'h07, 5'h02, 5'h11});
        run(FR + 2);
        chk("t4_ack_count", 8'(ack_seen), 8'd1);

        // 5: drop enable in SHOW pos3, load while off, re-enable
        run_until(3 * PER + 1);
        step(1'b0, 1'b0, 30'd0);
        chk("t5_off_pos", 8'(digit_pos), 8'h07);
        repeat (2) step(1'b0, 1'b0, 30'd0);
        ack_seen = 0;
        step(1'b0, 1'b1, {5'h05, 5'h04, 5'h03, 5'h02, 5'h01, 5'h00});
        repeat (3) step(1'b0, 1'b0, 30'd0);
        chk("t5_off_ack_count", 8'(ack_seen), 8'd1);
        fs_seen = 0;
        step(1'b1, 1'b0, 30'd0);
        chk("t5_restart_frame_start", 8'(fs_seen), 8'd1);
        run(FR + 5);

        // 6: asynchronous reset mid-SHOW, then the buffer must be blank again
        run_until(2 * PER + 2);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        model_reset();
        @(posedge clk);
        #1;
        check_reset_outputs("held_reset");
        rst_n = 1'b1;
        run(FR + 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
